// File: rtl/ultrasonico_pkg.sv
// Shared definitions for the multi-channel ultrasonic ranger: FSM state codes
// and a width helper for channel indices and divider counters.
package ultrasonico_pkg;

    typedef logic [2:0] state_t;

    localparam logic [2:0] ST_IDLE      = 3'd0;
    localparam logic [2:0] ST_TRIGGER   = 3'd1;
    localparam logic [2:0] ST_ESPERANDO = 3'd2;
    localparam logic [2:0] ST_SENSANDO  = 3'd3;
    localparam logic [2:0] ST_ENVIANDO  = 3'd4;
    localparam logic [2:0] ST_HOLDOFF   = 3'd5;

    // clog2 with a floor of one bit so a single-entry range still gets a signal.
    function automatic int ch_width(input int n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/sensor_ultrasonico_multi_if.sv
// Control, echo and result bundle of the ultrasonic ranger; the slave side is
// the ranger, the master side is whoever drives enable/umbral/eco.
interface sensor_ultrasonico_multi_if #(
    parameter int N_CH  = 4,
    parameter int CNT_W = 16
);
    import ultrasonico_pkg::*;

    localparam int CH_W = ch_width(N_CH);

    logic              enable;
    logic [CNT_W-1:0]  umbral;
    logic [N_CH-1:0]   eco;
    logic [N_CH-1:0]   trigger;
    logic [N_CH-1:0]   interferencia;
    logic [CNT_W-1:0]  dist_us;
    logic [CH_W-1:0]   dist_ch;
    logic              dist_valid;
    logic              timeout_err;

    modport master (
        output enable, umbral, eco,
        input  trigger, interferencia, dist_us, dist_ch, dist_valid, timeout_err
    );

    modport slave (
        input  enable, umbral, eco,
        output trigger, interferencia, dist_us, dist_ch, dist_valid, timeout_err
    );

endinterface

// File: rtl/us_tick_gen.sv
// Microsecond strobe: tick is high for one clk out of every CLKS_PER_US clks.
module us_tick_gen
    import ultrasonico_pkg::*;
#(
    parameter int CLKS_PER_US = 50
) (
    input  logic clk,
    input  logic reset,
    output logic tick
);

    localparam int              DIV_W = ch_width(CLKS_PER_US);
    localparam logic [DIV_W-1:0] LAST = DIV_W'(CLKS_PER_US - 1);

    logic [DIV_W-1:0] div_q;
    logic [DIV_W-1:0] div_d;

    always_comb begin
        div_d = (div_q == LAST) ? '0 : div_q + 1'b1;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            div_q <= '0;
        end else begin
            div_q <= div_d;
        end
    end

    assign tick = (div_q == LAST);

endmodule

// File: rtl/sensor_ultrasonico_multi.sv
// Round-robin ultrasonic ranger: fires one channel at a time, measures the echo
// width in microseconds, reports it and flags echoes shorter than umbral.
module sensor_ultrasonico_multi
    import ultrasonico_pkg::*;
#(
    parameter int CLKS_PER_US = 50,
    parameter int N_CH        = 4,
    parameter int CNT_W       = 16,
    parameter int TRIG_US     = 10,
    parameter int TIMEOUT_US  = 30000,
    parameter int HOLDOFF_US  = 60000
) (
    input  logic                       clk,
    input  logic                       reset,
    sensor_ultrasonico_multi_if.slave  bus
);

    localparam int               CH_W        = ch_width(N_CH);
    localparam logic [31:0]      TRIG_LAST   = 32'(TRIG_US - 1);
    localparam logic [31:0]      TIMEOUT_LIM = 32'(TIMEOUT_US);
    localparam logic [31:0]      HOLD_LAST   = 32'(HOLDOFF_US - 1);
    localparam logic [CNT_W-1:0] CNT_MAX     = '1;
    localparam logic [CH_W-1:0]  CH_LAST     = CH_W'(N_CH - 1);

    logic tick;

    us_tick_gen #(.CLKS_PER_US(CLKS_PER_US)) u_tick (
        .clk   (clk),
        .reset (reset),
        .tick  (tick)
    );

    logic [N_CH-1:0]  eco_s1_q, eco_s2_q;
    state_t           state_q, state_d;
    logic [CH_W-1:0]  ch_q, ch_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [31:0]      tmr_q, tmr_d;
    logic [N_CH-1:0]  trigger_q, trigger_d;
    logic [N_CH-1:0]  interf_q, interf_d;
    logic [CNT_W-1:0] dist_us_q, dist_us_d;
    logic [CH_W-1:0]  dist_ch_q, dist_ch_d;
    logic             dist_valid_q, dist_valid_d;
    logic             timeout_q, timeout_d;

    logic [N_CH-1:0]  ch_oh_q, ch_oh_d;
    logic             eco_cur;
    logic [31:0]      tmr_inc;
    logic             timed_out;
    logic [CNT_W-1:0] cnt_sat;
    logic             to_flag;
    logic             enter_env;
    logic             near;

    for (genvar gi = 0; gi < N_CH; gi++) begin : g_onehot
        assign ch_oh_q[gi] = (ch_q == CH_W'(gi));
        assign ch_oh_d[gi] = (ch_d == CH_W'(gi));
    end

    // Only the active channel's synchronized echo is ever looked at.
    assign eco_cur   = |(eco_s2_q & ch_oh_q);
    assign tmr_inc   = tmr_q + 32'd1;
    assign timed_out = (tmr_inc >= TIMEOUT_LIM);
    assign cnt_sat   = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + 1'b1;

    always_comb begin
        state_d = state_q;
        ch_d    = ch_q;
        cnt_d   = cnt_q;
        tmr_d   = tmr_q;
        to_flag = 1'b0;
        if (tick) begin
            case (state_q)
                ST_IDLE: begin
                    if (bus.enable) begin
                        state_d = ST_TRIGGER;
                        cnt_d   = '0;
                        tmr_d   = '0;
                    end
                end
                ST_TRIGGER: begin
                    if (tmr_q == TRIG_LAST) begin
                        state_d = ST_ESPERANDO;
                        cnt_d   = '0;
                        tmr_d   = '0;
                    end else begin
                        tmr_d = tmr_inc;
                    end
                end
                ST_ESPERANDO: begin
                    tmr_d = tmr_inc;
                    if (timed_out) begin
                        state_d = ST_ENVIANDO;
                        to_flag = 1'b1;
                    end else if (eco_cur) begin
                        state_d = ST_SENSANDO;
                        cnt_d   = '0;
                    end
                end
                ST_SENSANDO: begin
                    // The tick that sees the falling edge still counts, so N high
                    // ticks report exactly N.
                    tmr_d = tmr_inc;
                    cnt_d = cnt_sat;
                    if (timed_out) begin
                        state_d = ST_ENVIANDO;
                        to_flag = 1'b1;
                    end else if (!eco_cur) begin
                        state_d = ST_ENVIANDO;
                    end
                end
                ST_ENVIANDO: begin
                    state_d = ST_HOLDOFF;
                    tmr_d   = '0;
                end
                ST_HOLDOFF: begin
                    if (tmr_q == HOLD_LAST) begin
                        ch_d    = (ch_q == CH_LAST) ? '0 : ch_q + 1'b1;
                        state_d = bus.enable ? ST_TRIGGER : ST_IDLE;
                        cnt_d   = '0;
                        tmr_d   = '0;
                    end else begin
                        tmr_d = tmr_inc;
                    end
                end
                default: begin
                    state_d = ST_IDLE;
                end
            endcase
        end

        trigger_d = (state_d == ST_TRIGGER) ? ch_oh_d : '0;

        enter_env    = (state_d == ST_ENVIANDO) && (state_q != ST_ENVIANDO);
        near         = !to_flag && (cnt_d != '0) && (cnt_d < bus.umbral);
        dist_valid_d = enter_env;
        dist_us_d    = dist_us_q;
        dist_ch_d    = dist_ch_q;
        timeout_d    = timeout_q;
        interf_d     = interf_q;
        if (enter_env) begin
            dist_us_d = to_flag ? CNT_MAX : cnt_d;
            dist_ch_d = ch_q;
            timeout_d = to_flag;
            interf_d  = (interf_q & ~ch_oh_q) | (near ? ch_oh_q : '0);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            eco_s1_q     <= '0;
            eco_s2_q     <= '0;
            state_q      <= ST_IDLE;
            ch_q         <= '0;
            cnt_q        <= '0;
            tmr_q        <= '0;
            trigger_q    <= '0;
            interf_q     <= '0;
            dist_us_q    <= '0;
            dist_ch_q    <= '0;
            dist_valid_q <= 1'b0;
            timeout_q    <= 1'b0;
        end else begin
            eco_s1_q     <= bus.eco;
            eco_s2_q     <= eco_s1_q;
            state_q      <= state_d;
            ch_q         <= ch_d;
            cnt_q        <= cnt_d;
            tmr_q        <= tmr_d;
            trigger_q    <= trigger_d;
            interf_q     <= interf_d;
            dist_us_q    <= dist_us_d;
            dist_ch_q    <= dist_ch_d;
            dist_valid_q <= dist_valid_d;
            timeout_q    <= timeout_d;
        end
    end

    assign bus.trigger       = trigger_q;
    assign bus.interferencia = interf_q;
    assign bus.dist_us       = dist_us_q;
    assign bus.dist_ch       = dist_ch_q;
    assign bus.dist_valid    = dist_valid_q;
    assign bus.timeout_err   = timeout_q;

endmodule

// File: tb/tb_sensor_ultrasonico_multi.sv
// Directed bench: ranging, interference flag, channel rotation, reset abort and
// enable drop on one instance; echo timeout on a second, short-timeout instance.
module tb_sensor_ultrasonico_multi;

    localparam int CPU     = 2;
    localparam int TRIG_US = 10;
    localparam int HOLD_US = 50;
    localparam int TO_B    = 500;

    logic clk   = 1'b0;
    logic reset = 1'b1;
    int   n_cmp = 0;
    int   n_bad = 0;
    int   two_hot = 0;
    int   n;
    int   trig_seen;

    always #5 clk = ~clk;

    sensor_ultrasonico_multi_if #(.N_CH(2), .CNT_W(16)) bus_a ();
    sensor_ultrasonico_multi_if #(.N_CH(2), .CNT_W(16)) bus_b ();

    sensor_ultrasonico_multi #(
        .CLKS_PER_US(CPU), .N_CH(2), .CNT_W(16), .TRIG_US(TRIG_US),
        .TIMEOUT_US(30000), .HOLDOFF_US(HOLD_US)
    ) dut_a (
        .clk   (clk),
        .reset (reset),
        .bus   (bus_a)
    );

    sensor_ultrasonico_multi #(
        .CLKS_PER_US(CPU), .N_CH(2), .CNT_W(16), .TRIG_US(TRIG_US),
        .TIMEOUT_US(TO_B), .HOLDOFF_US(HOLD_US)
    ) dut_b (
        .clk   (clk),
        .reset (reset),
        .bus   (bus_b)
    );

    always @(negedge clk) begin
        if ($countones(bus_a.trigger) > 1) two_hot++;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    function automatic logic cond(input int what);
        case (what)
            0:       return bus_a.trigger != 2'b00;
            1:       return bus_a.trigger == 2'b00;
            2:       return bus_a.dist_valid;
            3:       return bus_b.trigger != 2'b00;
            4:       return bus_b.trigger == 2'b00;
            5:       return bus_b.dist_valid;
            default: return 1'b0;
        endcase
    endfunction

    // Advance negedge by negedge until the condition holds; n = edges advanced.
    task automatic wait_for(input string tag, input int what, input int budget, output int cnt);
        cnt = 0;
        while (!cond(what) && cnt < budget) begin
            @(negedge clk);
            cnt++;
        end
        check(tag, 32'(cond(what)), 32'd1);
    endtask

    task automatic echo_a(input int ch, input int width_us);
        bus_a.eco[ch] = 1'b1;
        repeat (width_us * CPU) @(negedge clk);
        bus_a.eco[ch] = 1'b0;
    endtask

    initial begin
        bus_a.enable = 1'b0;
        bus_a.umbral = 16'd2500;
        bus_a.eco    = 2'b00;
        bus_b.enable = 1'b0;
        bus_b.umbral = 16'd2500;
        bus_b.eco    = 2'b00;
        repeat (3) @(negedge clk);

        check("rst_trigger",    32'(bus_a.trigger),       0);
        check("rst_interf",     32'(bus_a.interferencia), 0);
        check("rst_dist_us",    32'(bus_a.dist_us),       0);
        check("rst_dist_ch",    32'(bus_a.dist_ch),       0);
        check("rst_dist_valid", 32'(bus_a.dist_valid),    0);
        check("rst_timeout",    32'(bus_a.timeout_err),   0);

        // ch0, 1000 us echo with noise on ch1
        bus_a.enable = 1'b1;
        reset = 1'b0;
        wait_for("trig0_rise", 0, 50, n);
        check("trig0_onehot", 32'(bus_a.trigger), 32'b01);
        wait_for("trig0_fall", 1, 100, n);
        check("trig0_width_clks", 32'(n), 32'(TRIG_US * CPU));
        repeat (40) @(negedge clk);
        bus_a.eco[1] = 1'b1;
        repeat (10) @(negedge clk);
        echo_a(0, 1000);
        bus_a.eco[1] = 1'b0;
        wait_for("res0_valid", 2, 50, n);
        check("res0_dist_us",  32'(bus_a.dist_us),       1000);
        check("res0_dist_ch",  32'(bus_a.dist_ch),       0);
        check("res0_timeout",  32'(bus_a.timeout_err),   0);
        check("res0_interf",   32'(bus_a.interferencia), 32'b01);
        @(negedge clk);
        check("res0_strobe_len", 32'(bus_a.dist_valid), 0);

        // ENVIANDO (one tick) plus HOLDOFF_US ticks before ch1 fires
        wait_for("trig1_rise", 0, 400, n);
        check("holdoff_clks", 32'(n + 1), 32'((1 + HOLD_US) * CPU));
        check("trig1_onehot", 32'(bus_a.trigger), 32'b10);
        wait_for("trig1_fall", 1, 100, n);
        repeat (20) @(negedge clk);
        bus_a.eco[0] = 1'b1;
        echo_a(1, 200);
        bus_a.eco[0] = 1'b0;
        wait_for("res1_valid", 2, 50, n);
        check("res1_dist_us", 32'(bus_a.dist_us),       200);
        check("res1_dist_ch", 32'(bus_a.dist_ch),       1);
        check("res1_interf",  32'(bus_a.interferencia), 32'b11);

        // wrap back to ch0, 3000 us echo is above umbral
        wait_for("trig2_rise", 0, 400, n);
        check("trig2_onehot", 32'(bus_a.trigger), 32'b01);
        wait_for("trig2_fall", 1, 100, n);
        repeat (20) @(negedge clk);
        echo_a(0, 3000);
        wait_for("res2_valid", 2, 50, n);
        check("res2_dist_us",  32'(bus_a.dist_us),       3000);
        check("res2_dist_ch",  32'(bus_a.dist_ch),       0);
        check("res2_timeout",  32'(bus_a.timeout_err),   0);
        check("res2_interf",   32'(bus_a.interferencia), 32'b10);

        // reset in the middle of a ch1 echo
        wait_for("trig3_rise", 0, 400, n);
        check("trig3_onehot", 32'(bus_a.trigger), 32'b10);
        wait_for("trig3_fall", 1, 100, n);
        repeat (20) @(negedge clk);
        bus_a.eco[1] = 1'b1;
        repeat (100) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        bus_a.eco[1] = 1'b0;
        check("mid_rst_trigger",    32'(bus_a.trigger),       0);
        check("mid_rst_interf",     32'(bus_a.interferencia), 0);
        check("mid_rst_dist_us",    32'(bus_a.dist_us),       0);
        check("mid_rst_dist_ch",    32'(bus_a.dist_ch),       0);
        check("mid_rst_dist_valid", 32'(bus_a.dist_valid),    0);
        check("mid_rst_timeout",    32'(bus_a.timeout_err),   0);
        wait_for("trig4_rise", 0, 50, n);
        check("trig4_onehot", 32'(bus_a.trigger), 32'b01);

        // enable dropped mid-echo: result still reported, then no more triggers
        wait_for("trig4_fall", 1, 100, n);
        repeat (20) @(negedge clk);
        bus_a.eco[0] = 1'b1;
        repeat (100) @(negedge clk);
        bus_a.enable = 1'b0;
        repeat (300) @(negedge clk);
        bus_a.eco[0] = 1'b0;
        wait_for("res4_valid", 2, 50, n);
        check("res4_dist_us", 32'(bus_a.dist_us),       200);
        check("res4_dist_ch", 32'(bus_a.dist_ch),       0);
        check("res4_timeout", 32'(bus_a.timeout_err),   0);
        check("res4_interf",  32'(bus_a.interferencia), 32'b01);
        trig_seen = 0;
        repeat (400) begin
            @(negedge clk);
            if (bus_a.trigger != 2'b00) trig_seen++;
        end
        check("no_retrigger", 32'(trig_seen), 0);

        // timeout on the second instance: no echo at all
        bus_b.enable = 1'b1;
        wait_for("b_trig_rise", 3, 50, n);
        check("b_trig_onehot", 32'(bus_b.trigger), 32'b01);
        wait_for("b_trig_fall", 4, 100, n);
        wait_for("b_valid", 5, 1200, n);
        check("b_timeout_clks", 32'(n), 32'(TO_B * CPU));
        check("b_dist_us",  32'(bus_b.dist_us),       32'hFFFF);
        check("b_timeout",  32'(bus_b.timeout_err),   1);
        check("b_interf",   32'(bus_b.interferencia), 0);
        check("b_dist_ch",  32'(bus_b.dist_ch),       0);
        bus_b.enable = 1'b0;

        check("never_two_hot", 32'(two_hot), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
